// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR,
// with bus handshakes, gated register-file writes and sticky halt/error stops.
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    output logic [31:0] ifu_addr,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] id_inst,
    input  logic [31:0] exu_next_pc,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_done,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halt,
    output logic        err
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_t;
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_q, ir_q, instret_q;
    logic             ifu_req_q, lsu_req_q, lsu_wen_q, rf_wen_q, retire_q, halt_q, err_q;
    logic [6:0]       opc;
    logic             is_load, is_store, is_branch, is_mem, is_ebreak, legal, waiting, wr_rd;
    assign opc       = ir_q[6:0];
    assign is_load   = opc == 7'b0000011;
    assign is_store  = opc == 7'b0100011;
    assign is_branch = opc == 7'b1100011;
    assign is_mem    = is_load || is_store;
    assign is_ebreak = ir_q == EBREAK;
    assign legal     = opc inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    assign wr_rd     = !(is_branch || is_store) && ir_q[11:7] != 5'd0;
    // The first FETCH cycle after reset has ifu_req low, so neither accept nor count there
    assign waiting   = (state_q == FETCH && ifu_req_q) || state_q == MEM;
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (ifu_req_q) state_d = ifu_valid ? DECODE : (cnt_q == TO ? ERR : FETCH);
            DECODE:  state_d = is_ebreak ? HALT : (legal ? EXEC : ERR);
            EXEC:    state_d = is_mem ? MEM : WB;
            MEM:     state_d = lsu_done ? WB : (cnt_q == TO ? ERR : MEM);
            WB:      state_d = FETCH;
            default: state_d = state_q;
        endcase
    end
    assign cnt_d = (state_d != state_q) ? '0 : (waiting ? cnt_q + CNT_W'(1) : cnt_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            instret_q <= '0;
            ifu_req_q <= 1'b0;
            lsu_req_q <= 1'b0;
            lsu_wen_q <= 1'b0;
            rf_wen_q  <= 1'b0;
            retire_q  <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == FETCH && ifu_req_q && ifu_valid) ir_q <= ifu_rdata;
            if (state_q == WB) begin
                pc_q      <= exu_next_pc;
                instret_q <= instret_q + 32'd1;
            end
            ifu_req_q <= state_d == FETCH;
            lsu_req_q <= state_d == MEM;
            lsu_wen_q <= state_d == MEM && is_store;
            rf_wen_q  <= state_d == WB && wr_rd;
            retire_q  <= state_d == WB;
            halt_q    <= state_d == HALT;
            err_q     <= state_d == ERR;
        end
    end
    assign ifu_req  = ifu_req_q;
    assign ifu_addr = pc_q;
    assign id_inst  = ir_q;
    assign lsu_req  = lsu_req_q;
    assign lsu_wen  = lsu_wen_q;
    assign rf_wen   = rf_wen_q;
    assign pc       = pc_q;
    assign retire   = retire_q;
    assign instret  = instret_q;
    assign halt     = halt_q;
    assign err      = err_q;
endmodule
